// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing checker: recovers pixel coordinates from hs/vs/hen/ven,
// measures line/frame totals against the expected format and reports lock.
module vga_sync_rx #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 600,
  parameter int H_TOT       = 1040,
  parameter int V_TOT       = 666,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_px,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        hen,
  input  logic        ven,
  output logic        de,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        sof,
  output logic        eol,
  output logic        err_h,
  output logic        err_v,
  output logic        locked,
  output logic [15:0] h_total_meas,
  output logic [15:0] v_total_meas
);

  localparam logic [15:0] H_ACT_W  = 16'(H_ACT);
  localparam logic [15:0] V_ACT_W  = 16'(V_ACT);
  localparam logic [15:0] H_TOT_W  = 16'(H_TOT);
  localparam logic [15:0] V_TOT_W  = 16'(V_TOT);
  localparam logic [3:0]  LOCK_W   = 4'(LOCK_FRAMES);
  localparam logic [15:0] SAT      = 16'hFFFF;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      r_state, w_stateNext;
  logic [3:0]  r_good, w_goodNext;

  logic        r_hs1, r_hs2, r_vs1, r_vs2, r_hen1, r_hen2, r_ven1, r_ven2;
  logic [15:0] r_hcnt, r_vcnt, r_acnt, r_y;
  logic        r_hFirst, r_errSeen;
  logic        r_de, r_sof, r_eol, r_errH, r_errV, r_locked;
  logic [15:0] r_x, r_hMeas, r_vMeas;

  logic        w_hsRise, w_vsRise, w_henFall, w_venFall, w_eol;
  logic        w_lost, w_errH, w_errV, w_anyErr;
  logic [15:0] w_hMeas, w_vMeas;

  always_ff @(posedge clk_px or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1  <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs1  <= 1'b0;
      r_vs2  <= 1'b0;
      r_hen1 <= 1'b0;
      r_hen2 <= 1'b0;
      r_ven1 <= 1'b0;
      r_ven2 <= 1'b0;
    end else begin
      r_hs1  <= hs;
      r_hs2  <= r_hs1;
      r_vs1  <= vs;
      r_vs2  <= r_vs1;
      r_hen1 <= hen;
      r_hen2 <= r_hen1;
      r_ven1 <= ven;
      r_ven2 <= r_ven1;
    end
  end

  assign w_hsRise  = r_hs1 & ~r_hs2;
  assign w_vsRise  = r_vs1 & ~r_vs2;
  assign w_henFall = ~r_hen1 & r_hen2;
  assign w_venFall = ~r_ven1 & r_ven2;
  assign w_eol     = w_henFall & r_ven1;

  // A returning hs edge ends the timeout, so the first vs after recovery is not swallowed.
  assign w_lost  = (r_hcnt == SAT) & ~w_hsRise;
  assign w_hMeas = (r_hcnt == SAT) ? SAT : r_hcnt + 16'd1;
  assign w_vMeas = (r_vcnt == SAT) ? SAT : r_vcnt + 16'd1;

  assign w_errH   = (w_hsRise & ~r_hFirst & (w_hMeas != H_TOT_W))
                  | (w_eol & (r_acnt != H_ACT_W));
  assign w_errV   = (w_venFall & (r_y != V_ACT_W))
                  | (w_vsRise & (r_state != SEARCH) & (w_vMeas != V_TOT_W));
  assign w_anyErr = w_errH | w_errV;

  always_ff @(posedge clk_px or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_acnt    <= '0;
      r_y       <= '0;
      r_hFirst  <= 1'b1;
      r_errSeen <= 1'b0;
      r_hMeas   <= '0;
      r_vMeas   <= '0;
      r_de      <= 1'b0;
      r_x       <= '0;
      r_sof     <= 1'b0;
      r_eol     <= 1'b0;
      r_errH    <= 1'b0;
      r_errV    <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      if (w_hsRise)           r_hcnt <= '0;
      else if (r_hcnt != SAT) r_hcnt <= r_hcnt + 16'd1;

      if (w_vsRise)                         r_vcnt <= '0;
      else if (w_hsRise && r_vcnt != SAT)   r_vcnt <= r_vcnt + 16'd1;

      if (w_hsRise)                         r_acnt <= '0;
      else if (r_hen1 && r_acnt != SAT)     r_acnt <= r_acnt + 16'd1;

      if (w_vsRise)   r_y <= '0;
      else if (w_eol) r_y <= r_y + 16'd1;

      if (w_hsRise)    r_hFirst <= 1'b0;
      else if (w_lost) r_hFirst <= 1'b1;

      // Errors seen on the vs edge itself are charged to the frame that just ended.
      if (w_lost || w_vsRise) r_errSeen <= 1'b0;
      else if (w_anyErr)      r_errSeen <= 1'b1;

      if (w_hsRise) r_hMeas <= w_hMeas;
      if (w_vsRise) r_vMeas <= w_vMeas;

      r_de     <= r_hen1 & r_ven1;
      r_x      <= (r_hen1 & r_ven1) ? r_acnt : 16'd0;
      r_sof    <= w_vsRise;
      r_eol    <= w_eol;
      r_errH   <= w_errH;
      r_errV   <= w_errV;
      r_locked <= (r_state == LOCKED);
    end
  end

  always_ff @(posedge clk_px or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEARCH;
      r_good  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_good  <= w_goodNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_goodNext  = r_good;
    case (r_state)
      SEARCH: begin
        if (w_vsRise) begin
          w_stateNext = CHECK;
          w_goodNext  = '0;
        end
      end
      CHECK: begin
        if (w_vsRise) begin
          if (!r_errSeen && !w_anyErr) begin
            w_goodNext = r_good + 4'd1;
            if (r_good + 4'd1 == LOCK_W) w_stateNext = LOCKED;
          end else begin
            w_goodNext = '0;
          end
        end else if (w_anyErr) begin
          w_goodNext = '0;
        end
      end
      LOCKED: begin
        if (w_anyErr) begin
          w_stateNext = CHECK;
          w_goodNext  = '0;
        end
      end
      default: begin
        w_stateNext = SEARCH;
        w_goodNext  = '0;
      end
    endcase
    if (w_lost) begin
      w_stateNext = SEARCH;
      w_goodNext  = '0;
    end
  end

  assign de           = r_de;
  assign x            = r_x;
  assign y            = r_y;
  assign sof          = r_sof;
  assign eol          = r_eol;
  assign err_h        = r_errH;
  assign err_v        = r_errV;
  assign locked       = r_locked;
  assign h_total_meas = r_hMeas;
  assign v_total_meas = r_vMeas;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a shrunken raster (16x8 totals) so whole frames and the
// hs timeout fit in a short run; per-cycle expectations flow through a 2-deep scoreboard.
module tb_vga_sync_rx;

  localparam int HS  = 2;
  localparam int HBP = 2;
  localparam int HA  = 8;
  localparam int HFP = 4;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VSL = 1;
  localparam int VBP = 1;
  localparam int VA  = 4;
  localparam int VFP = 2;
  localparam int VT  = VSL + VBP + VA + VFP;

  logic        clk_px = 1'b0;
  logic        rst_n  = 1'b0;
  logic        hs = 1'b0, vs = 1'b0, hen = 1'b0, ven = 1'b0;
  logic        de, sof, eol, err_h, err_v, locked;
  logic [15:0] x, y, h_total_meas, v_total_meas;

  vga_sync_rx #(
    .H_ACT(HA), .V_ACT(VA), .H_TOT(HT), .V_TOT(VT), .LOCK_FRAMES(2)
  ) dut (
    .clk_px(clk_px), .rst_n(rst_n), .hs(hs), .vs(vs), .hen(hen), .ven(ven),
    .de(de), .x(x), .y(y), .sof(sof), .eol(eol), .err_h(err_h), .err_v(err_v),
    .locked(locked), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
  );

  always #5 clk_px = ~clk_px;

  typedef struct {
    logic        de;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        errH;
    logic        errV;
    int          lockChk;
  } exp_t;

  typedef struct {
    int nLines;
    int shortLine;
    bit errVStart;
    int lockEvt;
    bit expLocked;
    int expVmeas;
  } frame_t;

  exp_t   sbq[$];
  frame_t frames[12];
  int     total = 0;
  int     bad   = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t idleExp();
    exp_t e;
    e.de = 1'b0; e.x = '0; e.y = '0; e.sof = 1'b0; e.eol = 1'b0;
    e.errH = 1'b0; e.errV = 1'b0; e.lockChk = -1;
    return e;
  endfunction

  // Outputs lag stimulus by two cycles, so the record pushed two steps ago is due now.
  task automatic applyStimulus(input logic h, input logic v, input logic he, input logic ve,
                               input exp_t e);
    exp_t p;
    @(negedge clk_px);
    if (sbq.size() >= 2) begin
      p = sbq.pop_front();
      checkOutput("de", 16'(de), 16'(p.de));
      checkOutput("sof", 16'(sof), 16'(p.sof));
      checkOutput("eol", 16'(eol), 16'(p.eol));
      checkOutput("err_h", 16'(err_h), 16'(p.errH));
      checkOutput("err_v", 16'(err_v), 16'(p.errV));
      if (p.de) begin
        checkOutput("x", x, p.x);
        checkOutput("y", y, p.y);
      end
      if (p.lockChk >= 0) checkOutput("locked_edge", 16'(locked), 16'(p.lockChk));
    end
    hs = h; vs = v; hen = he; ven = ve;
    sbq.push_back(e);
  endtask

  task automatic runFrame(input int nLines, input int shortLine, input bit errVStart,
                          input int lockEvt, input int maxSteps);
    int   steps;
    int   henEnd;
    logic h, v, he, ve;
    exp_t e;
    steps = 0;
    for (int l = 0; l < nLines; l++) begin
      henEnd = (l == shortLine) ? HS + HBP + HA - 1 : HS + HBP + HA;
      v  = (l < VSL);
      ve = (l >= VSL + VBP) && (l < VSL + VBP + VA);
      for (int c = 0; c < HT; c++) begin
        if (maxSteps > 0 && steps >= maxSteps) return;
        h  = (c < HS);
        he = (c >= HS + HBP) && (c < henEnd);
        e = idleExp();
        e.de   = he & ve;
        e.x    = 16'(c - (HS + HBP));
        e.y    = 16'(l - (VSL + VBP));
        e.sof  = (l == 0) && (c == 0);
        e.eol  = ve && (c == henEnd);
        e.errH = (l == shortLine) && (c == henEnd);
        e.errV = errVStart && (l == 0) && (c == 0);
        if (l == 0 && c == 0 && lockEvt == 1) e.lockChk = 0;
        if (l == 0 && c == 1 && lockEvt == 1) e.lockChk = 1;
        if (l == 0 && c == 0 && lockEvt == 2) e.lockChk = 1;
        if (l == 0 && c == 1 && lockEvt == 2) e.lockChk = 0;
        if (l == shortLine && c == henEnd)     e.lockChk = 1;
        if (l == shortLine && c == henEnd + 1) e.lockChk = 0;
        applyStimulus(h, v, he, ve, e);
        steps++;
      end
    end
  endtask

  task automatic runTableFrame(input int i);
    runFrame(frames[i].nLines, frames[i].shortLine, frames[i].errVStart, frames[i].lockEvt, 0);
    checkOutput("end_locked", 16'(locked), 16'(frames[i].expLocked));
    checkOutput("h_total_meas", h_total_meas, 16'(HT));
    if (frames[i].expVmeas >= 0) checkOutput("v_total_meas", v_total_meas, 16'(frames[i].expVmeas));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_de"}, 16'(de), 16'd0);
    checkOutput({tag, "_x"}, x, 16'd0);
    checkOutput({tag, "_y"}, y, 16'd0);
    checkOutput({tag, "_sof"}, 16'(sof), 16'd0);
    checkOutput({tag, "_eol"}, 16'(eol), 16'd0);
    checkOutput({tag, "_err_h"}, 16'(err_h), 16'd0);
    checkOutput({tag, "_err_v"}, 16'(err_v), 16'd0);
    checkOutput({tag, "_locked"}, 16'(locked), 16'd0);
    checkOutput({tag, "_hmeas"}, h_total_meas, 16'd0);
    checkOutput({tag, "_vmeas"}, v_total_meas, 16'd0);
  endtask

  initial begin
    // nLines, shortLine, errV at vs, lock event (1 rise / 2 drop at vs), locked at end, v_meas at end
    frames[0]  = '{VT,     -1, 1'b0, 0, 1'b0, -1};
    frames[1]  = '{VT,     -1, 1'b0, 0, 1'b0, VT};
    frames[2]  = '{VT,     -1, 1'b0, 1, 1'b1, VT};
    frames[3]  = '{VT,     -1, 1'b0, 0, 1'b1, VT};
    frames[4]  = '{VT,      3, 1'b0, 0, 1'b0, VT};
    frames[5]  = '{VT,     -1, 1'b0, 0, 1'b0, VT};
    frames[6]  = '{VT,     -1, 1'b0, 0, 1'b0, VT};
    frames[7]  = '{VT,     -1, 1'b0, 1, 1'b1, VT};
    frames[8]  = '{VT + 1, -1, 1'b0, 0, 1'b1, VT};
    frames[9]  = '{VT,     -1, 1'b1, 2, 1'b0, VT + 1};
    frames[10] = '{VT,     -1, 1'b0, 0, 1'b0, VT};
    frames[11] = '{VT,     -1, 1'b0, 1, 1'b1, VT};

    repeat (3) @(negedge clk_px);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp());
    for (int i = 0; i < 12; i++) runTableFrame(i);

    $display("[TB] holding hs low until the line counter saturates");
    repeat (70000) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp());
    checkOutput("lost_locked", 16'(locked), 16'd0);
    for (int i = 0; i < 3; i++) runTableFrame(i);

    $display("[TB] asserting reset mid-line");
    runFrame(VT, -1, 1'b0, 0, 3 * HT + 8);
    checkOutput("pre_reset_de", 16'(de), 16'd1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midreset");
    hs = 1'b0; vs = 1'b0; hen = 1'b0; ven = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk_px);
    rst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp());
    for (int i = 0; i < 3; i++) runTableFrame(i);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side companion to the display sync timing generator. It samples an incoming VGA timing stream (hs, vs, hen, ven) on the pixel clock and recovers per-pixel coordinates. It measures line and frame totals and checks them against the expected 800x600@72Hz format. A `locked` flag is asserted once consecutive frames are clean. It sits between the timing generator (or an external source) and pixel-consuming logic and self-check hardware.

## Interface
- H_ACT, 800: expected active pixels per line
- V_ACT, 600: expected active lines per frame
- H_TOT, 1040: expected clk_px cycles per line (120+64+800+56)
- V_TOT, 666: expected lines per frame (6+23+600+37)
- LOCK_FRAMES, 2: consecutive clean frames required for lock (1..15)

Ports:
- clk_px  in  1  pixel clock, 50 MHz
- rst_n  in  1  reset, active-low. One clock; reset is asynchronous and active-low.
- hs  in  1  line sync, active-high
- vs  in  1  frame sync, active-high
- hen  in  1  horizontal display enable
- ven  in  1  vertical display enable
- de  out  1  registered hen&ven; x/y are valid only while de=1
- x  out  16  pixel column, 0..H_ACT-1
- y  out  16  pixel row, 0..V_ACT-1
- sof  out  1  one-cycle pulse on frame start (vs rising)
- eol  out  1  one-cycle pulse at end of each active line
- err_h  out  1  one-cycle pulse on a line timing error
- err_v  out  1  one-cycle pulse on a frame timing error
- locked  out  1  stream matches the expected format
- h_total_meas  out  16  last measured line length in cycles
- v_total_meas  out  16  last measured frame length in lines

## Operation
- **Input stage:** two flops per input (r1, r2). Rising edge = r1&~r2; falling edge = ~r1&r2. All logic runs on r1/r2; no combinational input-to-output path.
- **hcnt (16b):** cleared to 0 on hs rise; otherwise increments, saturating at 0xFFFF.
  - On hs rise: h_total_meas<=hcnt+1.
  - err_h if hcnt+1≠H_TOT, except on the first hs rise after reset or timeout.
- **vcnt (16b):** counts hs rises.
  - On vs rise: v_total_meas<=vcnt+1 and vcnt<=0.
  - vs rise and hs rise in the same cycle: the vs action wins, and the hs measurement still occurs.
- **acnt:** counts hen-high cycles within a line.
  - Cleared on hs rise.
  - At hen fall with ven_r1=1: eol pulse; err_h if acnt≠H_ACT.
- **x:** equals acnt while de; held at 0 outside de.
- **y:** cleared on vs rise; increments at each eol.
  - At ven fall: err_v if y≠V_ACT.
  - At vs rise: err_v if vcnt+1≠V_TOT (skipped on the first vs after SEARCH).
- **Lock FSM (good counter 4b):**
  - SEARCH: locked=0; first vs rise → CHECK with good=0.
  - CHECK: at each vs rise, if no err pulse occurred since the previous vs rise, good++; when good==LOCK_FRAMES → LOCKED. Any err pulse clears good and stays in CHECK.
  - LOCKED: locked=1. Any err pulse → CHECK with good=0, and locked deasserts the next cycle.
  - Any state: hcnt reaching 0xFFFF (lost hs) → SEARCH, and all measurement/check skip flags re-arm.
- **Width rules:** all counters are unsigned 16b. Comparisons use 16b zero-extended parameters.

## Timing
- **Reset (async):** all outputs 0, FSM in SEARCH, counters and input flops 0. Reset asserted mid-frame clears everything immediately. Deassertion is sampled on the next clk_px rise.
- **Latency:** de, x, y, sof and eol follow input edges by 2 clk_px: 1 synchronizer cycle plus 1 output register. err_h/err_v and the meas outputs update in the same cycle as sof/eol for the triggering edge.
- **Pulse width:** sof, eol, err_h and err_v are exactly 1 cycle.
- **Lock timing:** locked rises 1 cycle after the vs rise that completes LOCK_FRAMES clean frames. With nominal input from reset, that is the (LOCK_FRAMES+1)-th vs rise.
- **Coordinate ordering:** x increments every cycle of de, giving 0..799 contiguously; y is constant within a line.

## Test plan
- **Nominal lock:** nominal 800x600@72 stream for 4 frames → locked=1 one cycle after the 3rd vs rise; h_total_meas=1040, v_total_meas=666; x spans 0..799 and y 0..599 during de; 600 eol pulses per frame; no err pulses.
- **Short active line:** after lock, one line with hen high 799 cycles → single err_h at that eol; locked drops next cycle; locked re-asserts after 2 further clean vs rises.
- **Long frame:** after lock, one frame with 667 lines → err_v at vs rise with v_total_meas=667; locked drops.
- **Lost hs:** hold hs low for 70000 cycles → locked=0 and FSM in SEARCH once hcnt saturates; no err pulse on the first hs/vs after recovery; relock after 3 vs rises.
- **Reset mid-frame:** assert rst_n=0 mid-line with de=1 → all outputs 0 immediately without waiting for a clock; after release, the nominal lock sequence repeats.
- **Coincident edges:** hs and vs rising in the same cycle → sof pulse, y=0 for the next frame, v_total_meas=666, no spurious err_h.
